cell_comm_tx_arbiter: RTL

- Packet-level round-robin arbiter sharing one Aurora cell-comm TX AXI-Stream (CCW or CW link) between two sources:
  - locally generated FA packets (loc)
  - packets forwarded from the opposite link (fwd)
- Runs in the link's Aurora user clock domain.
- Keeps packets atomic, gates traffic on channel-up, truncates runaway packets and keeps per-source statistics.

---
 rtl/cell_comm_tx_arbiter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/cell_comm_tx_arbiter.sv
// -----------------------------------------------------------------------------
// cell_comm_tx_arbiter
//
// Packet-level round-robin arbiter. It shares one Aurora cell-comm TX
// AXI-Stream between two sources: locally generated FA packets (loc) and
// packets forwarded from the opposite link (fwd). The block runs entirely
// in the Aurora user clock domain of the link it feeds.
//
// Packets are never interleaved. Traffic is gated on channelUp. A packet
// that reaches MAX_PKT_WORDS without its own tlast is cut at that length,
// and the rest of it is discarded. Per-source statistics are kept.
//
// Ports:
//   axisUserClk, axisUserReset   clock, synchronous active-high reset
//   channelUp                    Aurora channel up
//   loc*  / fwd*                 source AXI-Stream slaves (tvalid/tlast/tdata/tready)
//   tx*                          AXI-Stream master to Aurora TX
//   busy                         high whenever the arbiter is not in IDLE
//   locPktCount, fwdPktCount     packets completed on TX, per source
//   dropPktCount                 packets discarded because the channel was down
//   truncPktCount                packets cut at MAX_PKT_WORDS
// -----------------------------------------------------------------------------
module cell_comm_tx_arbiter #(
  parameter int MAX_PKT_WORDS = 64,  // 2..255
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 axisUserClk,
  input  logic                 axisUserReset,
  input  logic                 channelUp,
  input  logic                 locTvalid,
  input  logic                 locTlast,
  input  logic [31:0]          locTdata,
  output logic                 locTready,
  input  logic                 fwdTvalid,
  input  logic                 fwdTlast,
  input  logic [31:0]          fwdTdata,
  output logic                 fwdTready,
  output logic                 txTvalid,
  output logic                 txTlast,
  output logic [31:0]          txTdata,
  input  logic                 txTready,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] locPktCount,
  output logic [CNT_WIDTH-1:0] fwdPktCount,
  output logic [CNT_WIDTH-1:0] dropPktCount,
  output logic [CNT_WIDTH-1:0] truncPktCount
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_LOC,
    ST_SEND_FWD,
    ST_FLUSH_LOC,
    ST_FLUSH_FWD
  } state_e;

  typedef enum logic {
    SRC_LOC = 1'b0,
    SRC_FWD = 1'b1
  } src_e;

  localparam logic [7:0]           LAST_IDX = 8'(MAX_PKT_WORDS - 1);
  localparam logic [7:0]           WORD_ONE = 8'd1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  state_e               state_q,      state_d;
  src_e                 rr_last_q,    rr_last_d;
  logic [7:0]           word_cnt_q,   word_cnt_d;
  logic [CNT_WIDTH-1:0] loc_cnt_q,    loc_cnt_d;
  logic [CNT_WIDTH-1:0] fwd_cnt_q,    fwd_cnt_d;
  logic [CNT_WIDTH-1:0] drop_cnt_q,   drop_cnt_d;
  logic [CNT_WIDTH-1:0] trunc_cnt_q,  trunc_cnt_d;

  // Currently owned source (meaningful in SEND_x / FLUSH_x only).
  logic        sel_loc;
  src_e        cur_src;
  logic        src_valid;
  logic        src_last;
  logic [31:0] src_data;
  logic        force_last;
  logic        pick_loc;
  logic        beat;

  assign sel_loc    = (state_q == ST_SEND_LOC) || (state_q == ST_FLUSH_LOC);
  assign cur_src    = sel_loc ? SRC_LOC : SRC_FWD;
  assign src_valid  = sel_loc ? locTvalid : fwdTvalid;
  assign src_last   = sel_loc ? locTlast  : fwdTlast;
  assign src_data   = sel_loc ? locTdata  : fwdTdata;
  assign force_last = (word_cnt_q == LAST_IDX);
  // On a tie the source that did not go last wins; rr_last resets to fwd.
  assign pick_loc   = locTvalid && (!fwdTvalid || (rr_last_q == SRC_FWD));
  assign beat       = txTvalid && txTready;

  assign busy          = (state_q != ST_IDLE);
  assign locPktCount   = loc_cnt_q;
  assign fwdPktCount   = fwd_cnt_q;
  assign dropPktCount  = drop_cnt_q;
  assign truncPktCount = trunc_cnt_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can hold a stale value and infer a latch.
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    word_cnt_d  = word_cnt_q;
    loc_cnt_d   = loc_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    trunc_cnt_d = trunc_cnt_q;
    txTvalid    = 1'b0;
    txTlast     = 1'b0;
    txTdata     = '0;
    locTready   = 1'b0;
    fwdTready   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (locTvalid || fwdTvalid) begin
          if (channelUp) begin
            state_d = pick_loc ? ST_SEND_LOC : ST_SEND_FWD;
          end else begin
            // The whole packet is discarded; count it once, here.
            state_d    = pick_loc ? ST_FLUSH_LOC : ST_FLUSH_FWD;
            drop_cnt_d = drop_cnt_q + CNT_ONE;
          end
        end
      end

      ST_SEND_LOC, ST_SEND_FWD: begin
        // TX path is a plain mux of the owner; valid and ready are both gated
        // by channelUp so a beat can never happen while the link is down.
        txTvalid  = src_valid && channelUp;
        txTdata   = src_data;
        txTlast   = src_last || force_last;
        locTready = sel_loc  && txTready && channelUp;
        fwdTready = !sel_loc && txTready && channelUp;

        if (!channelUp) begin
          state_d    = sel_loc ? ST_FLUSH_LOC : ST_FLUSH_FWD;
          drop_cnt_d = drop_cnt_q + CNT_ONE;
          word_cnt_d = '0;
        end else if (beat) begin
          if (txTlast) begin
            word_cnt_d = '0;
            rr_last_d  = cur_src;
            if (sel_loc) loc_cnt_d = loc_cnt_q + CNT_ONE;
            else         fwd_cnt_d = fwd_cnt_q + CNT_ONE;
            if (force_last && !src_last) begin
              // Length limit hit: the remainder of the source packet is dropped.
              trunc_cnt_d = trunc_cnt_q + CNT_ONE;
              state_d     = sel_loc ? ST_FLUSH_LOC : ST_FLUSH_FWD;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            word_cnt_d = word_cnt_q + WORD_ONE;
          end
        end
      end

      ST_FLUSH_LOC, ST_FLUSH_FWD: begin
        locTready = sel_loc;
        fwdTready = !sel_loc;
        if (src_valid && src_last) begin
          rr_last_d = cur_src;
          state_d   = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge axisUserClk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before this edge, independent of block order.
    if (axisUserReset) begin
      state_q     <= ST_IDLE;
      rr_last_q   <= SRC_FWD;
      word_cnt_q  <= '0;
      loc_cnt_q   <= '0;
      fwd_cnt_q   <= '0;
      drop_cnt_q  <= '0;
      trunc_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      word_cnt_q  <= word_cnt_d;
      loc_cnt_q   <= loc_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      trunc_cnt_q <= trunc_cnt_d;
    end
  end

endmodule
